// File: rtl/inst_fetch_unit_if.sv
// Bus between the fetch unit, the instruction memory and the decode stage.
// The master side belongs to the fetch unit.
interface inst_fetch_unit_if #(
  parameter int PC_W = 8
);
  logic [PC_W-3:0] imem_addr;
  logic [31:0]     imem_data;
  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_is_compressed;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc, instr_is_compressed,
    input  imem_data, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc, instr_is_compressed,
    output imem_data, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// RV32IC fetch unit: tracks the PC, realigns 16/32-bit instructions across
// word boundaries with a halfword buffer, and feeds a registered decode stage.
module inst_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter logic [31:0]     NOP      = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  inst_fetch_unit_if.master fu
);
  typedef enum logic [1:0] {ALIGNED, MISALIGNED, BUFFERED} state_t;

  localparam logic [PC_W-1:0] HALF_MASK = ~PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     buf_q, buf_d;
  logic            instr_valid_q, instr_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            instr_is_compressed_q, instr_is_compressed_d;

  logic lo_is_c;
  logic buf_is_c;
  logic advance;

  assign lo_is_c  = (fu.imem_data[1:0] != 2'b11);
  assign buf_is_c = (buf_q[1:0] != 2'b11);
  assign advance  = !fu.stall && !fu.redirect_valid;

  // In BUFFERED the halfword at pc is already held, so fetch the following word.
  assign fu.imem_addr = (state_q == BUFFERED) ? pc_q[PC_W-1:2] + 1'b1 : pc_q[PC_W-1:2];

  assign fu.instr_valid         = instr_valid_q;
  assign fu.instr               = instr_q;
  assign fu.instr_pc            = instr_pc_q;
  assign fu.instr_is_compressed = instr_is_compressed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= ALIGNED;
      pc_q                  <= RESET_PC;
      buf_q                 <= 16'h0;
      instr_valid_q         <= 1'b0;
      instr_q               <= NOP;
      instr_pc_q            <= '0;
      instr_is_compressed_q <= 1'b0;
    end else begin
      state_q               <= state_d;
      pc_q                  <= pc_d;
      buf_q                 <= buf_d;
      instr_valid_q         <= instr_valid_d;
      instr_q               <= instr_d;
      instr_pc_q            <= instr_pc_d;
      instr_is_compressed_q <= instr_is_compressed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (fu.redirect_valid) begin
      pc_d    = fu.redirect_pc & HALF_MASK;
      state_d = fu.redirect_pc[1] ? MISALIGNED : ALIGNED;
      buf_d   = 16'h0;
    end else if (!fu.stall) begin
      case (state_q)
        ALIGNED: begin
          if (lo_is_c) begin
            buf_d   = fu.imem_data[31:16];
            pc_d    = pc_q + PC_W'(2);
            state_d = BUFFERED;
          end else begin
            pc_d = pc_q + PC_W'(4);
          end
        end
        MISALIGNED: begin
          buf_d   = fu.imem_data[31:16];
          state_d = BUFFERED;
        end
        BUFFERED: begin
          if (buf_is_c) begin
            pc_d    = pc_q + PC_W'(2);
            state_d = ALIGNED;
          end else begin
            buf_d = fu.imem_data[31:16];
            pc_d  = pc_q + PC_W'(4);
          end
        end
        default: state_d = ALIGNED;
      endcase
    end
  end

  always_comb begin
    instr_valid_d         = instr_valid_q;
    instr_d               = instr_q;
    instr_pc_d            = instr_pc_q;
    instr_is_compressed_d = instr_is_compressed_q;
    if (fu.redirect_valid) begin
      instr_valid_d         = 1'b0;
      instr_d               = NOP;
      instr_is_compressed_d = 1'b0;
    end else if (advance) begin
      instr_valid_d = 1'b1;
      instr_pc_d    = pc_q;
      case (state_q)
        ALIGNED: begin
          instr_d               = lo_is_c ? {16'h0, fu.imem_data[15:0]} : fu.imem_data;
          instr_is_compressed_d = lo_is_c;
        end
        BUFFERED: begin
          instr_d               = buf_is_c ? {16'h0, buf_q} : {fu.imem_data[15:0], buf_q};
          instr_is_compressed_d = buf_is_c;
        end
        default: begin
          instr_valid_d         = 1'b0;
          instr_d               = NOP;
          instr_pc_d            = instr_pc_q;
          instr_is_compressed_d = 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a scoreboard of expected emits
// and a monitor that checks each newly registered instruction.
module tb_inst_fetch_unit;
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  pc;
    logic        comp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [64];
  exp_t q[$];
  int total = 0;
  int bad = 0;

  inst_fetch_unit_if #(.PC_W(8)) ifc ();

  inst_fetch_unit #(.PC_W(8), .RESET_PC(8'h00), .NOP(32'h0000_0013)) dut (
    .clk (clk),
    .rst (rst),
    .fu  (ifc.master)
  );

  always #5 clk = ~clk;

  assign ifc.imem_data = mem[ifc.imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [7:0] p, input logic c);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    e.comp  = c;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: compare only on edges where the DUT registered a new output.
  initial begin
    bit upd;
    exp_t e;
    forever begin
      @(posedge clk);
      upd = !rst && (ifc.redirect_valid || !ifc.stall);
      #1;
      if (upd && ifc.instr_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_emit: got instr %h pc %h with nothing expected",
                   ifc.instr, ifc.instr_pc);
        end else begin
          e = q.pop_front();
          chk("emit_instr", ifc.instr, e.instr);
          chk("emit_pc", {24'h0, ifc.instr_pc}, {24'h0, e.pc});
          chk("emit_comp", {31'h0, ifc.instr_is_compressed}, {31'h0, e.comp});
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0001_0001;
    mem[0] = 32'h4085_0001;
    mem[1] = 32'h0093_0001;
    mem[2] = 32'h1234_00A0;
    mem[63] = 32'h00A0_0093;
    ifc.stall = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 8'h00;
    cyc();
    cyc();
    chk("rst_valid", {31'h0, ifc.instr_valid}, 32'h0);
    chk("rst_instr", ifc.instr, 32'h0000_0013);
    chk("rst_pc", {24'h0, ifc.instr_pc}, 32'h0);
    chk("rst_comp", {31'h0, ifc.instr_is_compressed}, 32'h0);
    chk("rst_addr", {26'h0, ifc.imem_addr}, 32'h0);
    rst = 1'b0;
    cyc();

    // Two compressed in word 0, then compressed + straddling 32-bit.
    push(32'h0000_0001, 8'h00, 1'b1);
    push(32'h0000_4085, 8'h02, 1'b1);
    push(32'h0000_0001, 8'h04, 1'b1);
    push(32'h00A0_0093, 8'h06, 1'b0);
    ifc.stall = 1'b0;
    cyc();
    cyc();
    chk("aligned_addr1", {26'h0, ifc.imem_addr}, 32'd1);
    cyc();
    chk("straddle_addr2", {26'h0, ifc.imem_addr}, 32'd2);
    cyc();
    ifc.stall = 1'b1;

    // Stall hold: outputs and address frozen for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_valid", {31'h0, ifc.instr_valid}, 32'h1);
      chk("stall_instr", ifc.instr, 32'h00A0_0093);
      chk("stall_pc", {24'h0, ifc.instr_pc}, 32'h06);
      chk("stall_addr", {26'h0, ifc.imem_addr}, 32'd3);
    end
    push(32'h0000_1234, 8'h0A, 1'b1);
    ifc.stall = 1'b0;
    cyc();

    // Redirect to an odd address while stalled: redirect wins.
    ifc.stall = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 8'h07;
    cyc();
    chk("redir_flush_valid", {31'h0, ifc.instr_valid}, 32'h0);
    chk("redir_flush_instr", ifc.instr, 32'h0000_0013);
    chk("redir_addr", {26'h0, ifc.imem_addr}, 32'd1);
    ifc.redirect_valid = 1'b0;
    ifc.stall = 1'b0;
    push(32'h00A0_0093, 8'h06, 1'b0);
    cyc();
    chk("misaligned_bubble", {31'h0, ifc.instr_valid}, 32'h0);
    chk("misaligned_comp", {31'h0, ifc.instr_is_compressed}, 32'h0);
    chk("buffered_addr", {26'h0, ifc.imem_addr}, 32'd2);
    cyc();
    ifc.stall = 1'b1;
    cyc();

    // Wrap: 32-bit at 0xFC, then word 0.
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 8'hFC;
    cyc();
    chk("wrap_addr63", {26'h0, ifc.imem_addr}, 32'd63);
    ifc.redirect_valid = 1'b0;
    ifc.stall = 1'b0;
    push(32'h00A0_0093, 8'hFC, 1'b0);
    push(32'h0000_0001, 8'h00, 1'b1);
    cyc();
    chk("wrap_addr0", {26'h0, ifc.imem_addr}, 32'd0);
    cyc();
    ifc.stall = 1'b1;

    // Wrap straddle: compressed at 0xFC, 32-bit spanning 0xFE into word 0.
    mem[63] = 32'h0093_0001;
    mem[0] = 32'h0000_00A0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 8'hFC;
    cyc();
    ifc.redirect_valid = 1'b0;
    ifc.stall = 1'b0;
    push(32'h0000_0001, 8'hFC, 1'b1);
    push(32'h00A0_0093, 8'hFE, 1'b0);
    cyc();
    chk("wrap_straddle_addr", {26'h0, ifc.imem_addr}, 32'd0);
    cyc();

    // Reset while BUFFERED (and stalled) must win.
    ifc.stall = 1'b1;
    rst = 1'b1;
    cyc();
    chk("midrst_valid", {31'h0, ifc.instr_valid}, 32'h0);
    chk("midrst_instr", ifc.instr, 32'h0000_0013);
    chk("midrst_pc", {24'h0, ifc.instr_pc}, 32'h0);
    chk("midrst_addr", {26'h0, ifc.imem_addr}, 32'd0);
    rst = 1'b0;
    ifc.stall = 1'b0;
    push(32'h0000_00A0, 8'h00, 1'b1);
    cyc();
    ifc.stall = 1'b1;
    cyc();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
